// File: rtl/lcd_pwr_seq.sv
// LCD panel power sequencer: rail/LVDS/backlight ordering, brightness
// level from key pulses, and a rate-limited duty ramp for the backlight PWM.
module lcd_pwr_seq #(
   parameter int unsigned T_PWR_LVDS = 330000,
   parameter int unsigned T_LVDS_BL  = 6600000,
   parameter int unsigned T_BL_LVDS  = 6600000,
   parameter int unsigned T_LVDS_PWR = 330000,
   parameter int unsigned T_OFF_MIN  = 16500000,
   parameter int unsigned RAMP_DIV   = 33,
   parameter int unsigned RAMP_STEP  = 128
) (
   input  logic        LPC_CLK33M_GMUX,
   input  logic        GMUX_RST,
   input  logic        PANEL_PWR_REQ,
   input  logic        BKL_REQ,
   input  logic        KEY_UP,
   input  logic        KEY_DOWN,
   output logic        LCD_PWR_EN,
   output logic        LVDS_OUT_EN,
   output logic        LCD_BKLT_EN,
   output logic [16:0] DUTY,
   output logic [4:0]  BRIGHT_LEVEL,
   output logic [2:0]  SEQ_STATE
);

   localparam int unsigned DUTY_W    = 17;
   localparam int unsigned LVL_W     = 5;
   localparam int unsigned MAX_LEVEL = 16;
   localparam int unsigned RST_LEVEL = 11;
   localparam int unsigned M1   = (T_PWR_LVDS > T_LVDS_BL) ? T_PWR_LVDS : T_LVDS_BL;
   localparam int unsigned M2   = (M1 > T_BL_LVDS) ? M1 : T_BL_LVDS;
   localparam int unsigned M3   = (M2 > T_LVDS_PWR) ? M2 : T_LVDS_PWR;
   localparam int unsigned TMAX = (M3 > T_OFF_MIN) ? M3 : T_OFF_MIN;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned DW   = $clog2(RAMP_DIV + 1);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_PWR_UP    = 3'd1,
      S_LVDS_UP   = 3'd2,
      S_RUN       = 3'd3,
      S_BL_DOWN   = 3'd4,
      S_LVDS_DOWN = 3'd5,
      S_PWR_DOWN  = 3'd6,
      S_COOL      = 3'd7
   } state_t;

   state_t              state, state_nxt;
   logic [TW-1:0]       timer, timer_nxt;
   logic [DW-1:0]       div, div_nxt;
   logic                lcd_pwr_nxt, lvds_nxt, bklt_nxt;
   logic [DUTY_W-1:0]   duty_nxt, target, diff, step;
   logic [LVL_W-1:0]    level_nxt;

   // Perceptual brightness curve, level -> duty compare value
   function automatic logic [DUTY_W-1:0] bright_table(input logic [LVL_W-1:0] lvl);
      case (lvl)
         5'd1:    bright_table = 17'd2854;
         5'd2:    bright_table = 17'd4281;
         5'd3:    bright_table = 17'd5708;
         5'd4:    bright_table = 17'd8563;
         5'd5:    bright_table = 17'd11417;
         5'd6:    bright_table = 17'd15698;
         5'd7:    bright_table = 17'd19980;
         5'd8:    bright_table = 17'd25688;
         5'd9:    bright_table = 17'd34251;
         5'd10:   bright_table = 17'd41386;
         5'd11:   bright_table = 17'd49949;
         5'd12:   bright_table = 17'd59939;
         5'd13:   bright_table = 17'd72783;
         5'd14:   bright_table = 17'd87054;
         5'd15:   bright_table = 17'd105606;
         5'd16:   bright_table = 17'd127013;
         default: bright_table = '0;
      endcase
   endfunction

   assign SEQ_STATE = state;

   // Next state, dwell timer and enable outputs
   always_comb begin
      state_nxt = state;
      timer_nxt = timer + TW'(1);
      bklt_nxt  = 1'b0;
      case (state)
         S_OFF: begin
            if (PANEL_PWR_REQ) state_nxt = S_PWR_UP;
         end
         S_PWR_UP: begin
            if (!PANEL_PWR_REQ)                         state_nxt = S_COOL;
            else if (timer == TW'(T_PWR_LVDS - 1))      state_nxt = S_LVDS_UP;
         end
         S_LVDS_UP: begin
            if (!PANEL_PWR_REQ)                         state_nxt = S_PWR_DOWN;
            else if (timer == TW'(T_LVDS_BL - 1))       state_nxt = S_RUN;
         end
         S_RUN: begin
            // Backlight stays lit until the ramp has actually reached zero
            bklt_nxt = BKL_REQ | (LCD_BKLT_EN & (DUTY != '0));
            if (!PANEL_PWR_REQ) state_nxt = S_BL_DOWN;
         end
         S_BL_DOWN: begin
            bklt_nxt = LCD_BKLT_EN;
            if (DUTY == '0) begin
               bklt_nxt  = 1'b0;
               state_nxt = S_LVDS_DOWN;
            end
         end
         S_LVDS_DOWN: begin
            if (timer == TW'(T_BL_LVDS - 1))  state_nxt = S_PWR_DOWN;
         end
         S_PWR_DOWN: begin
            if (timer == TW'(T_LVDS_PWR - 1)) state_nxt = S_COOL;
         end
         S_COOL: begin
            if (timer == TW'(T_OFF_MIN - 1))  state_nxt = S_OFF;
         end
         default: state_nxt = S_OFF;
      endcase
      if (state_nxt != state || state == S_OFF || state == S_RUN || state == S_BL_DOWN)
         timer_nxt = '0;
      lcd_pwr_nxt = (state_nxt != S_OFF) && (state_nxt != S_COOL);
      lvds_nxt    = (state_nxt == S_LVDS_UP) || (state_nxt == S_RUN) ||
                    (state_nxt == S_BL_DOWN) || (state_nxt == S_LVDS_DOWN);
   end

   // Duty ramp toward the current target, one bounded step per divider period
   always_comb begin
      target = '0;
      if (state == S_RUN && BKL_REQ) target = bright_table(BRIGHT_LEVEL);
      diff     = (target >= DUTY) ? (target - DUTY) : (DUTY - target);
      step     = (diff > DUTY_W'(RAMP_STEP)) ? DUTY_W'(RAMP_STEP) : diff;
      duty_nxt = DUTY;
      div_nxt  = div;
      if (state != S_RUN && state != S_BL_DOWN) begin
         duty_nxt = '0;
         div_nxt  = '0;
      end else if (div == DW'(RAMP_DIV - 1)) begin
         div_nxt  = '0;
         duty_nxt = (target >= DUTY) ? (DUTY + step) : (DUTY - step);
      end else begin
         div_nxt  = div + DW'(1);
      end
   end

   // Saturating brightness level; simultaneous keys cancel
   always_comb begin
      level_nxt = BRIGHT_LEVEL;
      if (KEY_UP && !KEY_DOWN && BRIGHT_LEVEL != LVL_W'(MAX_LEVEL))
         level_nxt = BRIGHT_LEVEL + LVL_W'(1);
      else if (KEY_DOWN && !KEY_UP && BRIGHT_LEVEL != '0)
         level_nxt = BRIGHT_LEVEL - LVL_W'(1);
   end

   // State and output registers
   always_ff @(posedge LPC_CLK33M_GMUX or posedge GMUX_RST) begin
      if (GMUX_RST) begin
         state        <= S_OFF;
         timer        <= '0;
         div          <= '0;
         LCD_PWR_EN   <= 1'b0;
         LVDS_OUT_EN  <= 1'b0;
         LCD_BKLT_EN  <= 1'b0;
         DUTY         <= '0;
         BRIGHT_LEVEL <= LVL_W'(RST_LEVEL);
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         div          <= div_nxt;
         LCD_PWR_EN   <= lcd_pwr_nxt;
         LVDS_OUT_EN  <= lvds_nxt;
         LCD_BKLT_EN  <= bklt_nxt;
         DUTY         <= duty_nxt;
         BRIGHT_LEVEL <= level_nxt;
      end
   end

endmodule

// File: tb/tb_lcd_pwr_seq.sv
// Directed bench for lcd_pwr_seq with short timing parameters.
module tb_lcd_pwr_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwr_req, bkl_req, key_up, key_down;
   logic        lcd_pwr_en, lvds_out_en, lcd_bklt_en;
   logic [16:0] duty;
   logic [4:0]  bright_level;
   logic [2:0]  seq_state;

   int n_cmp = 0;
   int n_err = 0;

   lcd_pwr_seq #(
      .T_PWR_LVDS(4), .T_LVDS_BL(3), .T_BL_LVDS(3), .T_LVDS_PWR(4),
      .T_OFF_MIN(8), .RAMP_DIV(1), .RAMP_STEP(10000)
   ) dut (
      .LPC_CLK33M_GMUX(clk),
      .GMUX_RST       (rst),
      .PANEL_PWR_REQ  (pwr_req),
      .BKL_REQ        (bkl_req),
      .KEY_UP         (key_up),
      .KEY_DOWN       (key_down),
      .LCD_PWR_EN     (lcd_pwr_en),
      .LVDS_OUT_EN    (lvds_out_en),
      .LCD_BKLT_EN    (lcd_bklt_en),
      .DUTY           (duty),
      .BRIGHT_LEVEL   (bright_level),
      .SEQ_STATE      (seq_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic all_out(input string tag, input int st, input int lcd, input int lvds,
                          input int bl, input int dty);
      chk({tag, "_state"}, 32'(seq_state), st);
      chk({tag, "_lcd"},   32'(lcd_pwr_en), lcd);
      chk({tag, "_lvds"},  32'(lvds_out_en), lvds);
      chk({tag, "_bklt"},  32'(lcd_bklt_en), bl);
      chk({tag, "_duty"},  32'(duty), dty);
   endtask

   initial begin
      rst = 1'b1; pwr_req = 1'b0; bkl_req = 1'b0; key_up = 1'b0; key_down = 1'b0;
      tick(); tick();
      all_out("rst", 0, 0, 0, 0, 0);
      chk("rst_level", 32'(bright_level), 11);
      rst = 1'b0;
      tick();
      chk("idle_state", 32'(seq_state), 0);

      // Power-up and initial ramp to level 11
      pwr_req = 1'b1; bkl_req = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         tick();
         all_out($sformatf("pu%0d", i),
                 (i < 5) ? 1 : (i < 8) ? 2 : 3,
                 1,
                 (i >= 5) ? 1 : 0,
                 (i >= 9) ? 1 : 0,
                 (i <= 8) ? 0 : (i < 13) ? (i - 8) * 10000 : 49949);
      end

      // Power-down; request reasserted during COOL must be ignored
      pwr_req = 1'b0;
      for (int j = 1; j <= 23; j++) begin
         tick();
         all_out($sformatf("pd%0d", j),
                 (j <= 6) ? 4 : (j <= 9) ? 5 : (j <= 13) ? 6 : (j <= 21) ? 7 : (j == 22) ? 0 : 1,
                 (j <= 13 || j == 23) ? 1 : 0,
                 (j <= 9) ? 1 : 0,
                 (j <= 6) ? 1 : 0,
                 (j == 1) ? 49949 : (j <= 5) ? 49949 - (j - 1) * 10000 : 0);
         if (j == 14) pwr_req = 1'b1;
      end
      for (int i = 0; i < 12; i++) tick();
      all_out("rerun", 3, 1, 1, 1, 49949);

      // Level up with saturation, ramp to full table value
      for (int i = 0; i < 6; i++) begin
         key_up = 1'b1; tick(); key_up = 1'b0; tick();
      end
      chk("lvl_max", 32'(bright_level), 16);
      for (int i = 0; i < 20; i++) tick();
      chk("duty_max", 32'(duty), 127013);

      // Level down to zero; backlight stays enabled while requested
      for (int i = 0; i < 20; i++) begin
         key_down = 1'b1; tick(); key_down = 1'b0; tick();
      end
      chk("lvl_min", 32'(bright_level), 0);
      for (int i = 0; i < 20; i++) tick();
      all_out("lvl0", 3, 1, 1, 1, 0);

      // Simultaneous keys cancel
      key_up = 1'b1; tick(); key_up = 1'b0; tick();
      chk("lvl_one", 32'(bright_level), 1);
      key_up = 1'b1; key_down = 1'b1; tick(); key_up = 1'b0; key_down = 1'b0; tick();
      chk("lvl_both", 32'(bright_level), 1);
      tick(); tick(); tick();
      chk("duty_lvl1", 32'(duty), 2854);

      // Backlight request drop in RUN ramps down then disables
      bkl_req = 1'b0;
      tick(); tick(); tick();
      all_out("bkl_off", 3, 1, 1, 0, 0);
      bkl_req = 1'b1;
      tick(); tick(); tick();
      all_out("bkl_on", 3, 1, 1, 1, 2854);

      // Reset during LVDS_DOWN abandons the sequence
      pwr_req = 1'b0;
      tick(); tick(); tick();
      chk("to_lvds_down", 32'(seq_state), 5);
      tick();
      rst = 1'b1;
      #2;
      all_out("async_rst", 0, 0, 0, 0, 0);
      chk("async_rst_level", 32'(bright_level), 11);
      @(posedge clk); #1;
      rst = 1'b0; pwr_req = 1'b1;
      tick();
      all_out("post_rst", 1, 1, 0, 0, 0);

      // Request dropped on the second PWR_UP cycle goes straight to COOL
      tick();
      chk("pu_cycle2", 32'(seq_state), 1);
      pwr_req = 1'b0;
      tick();
      all_out("abort", 7, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("abort_lvds%0d", k), 32'(lvds_out_en), 0);
         chk($sformatf("abort_state%0d", k), 32'(seq_state), (k < 8) ? 7 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
